// File: rtl/gnn_pkg.sv
// gnn_pkg: shared constants, FSM state encoding and the accumulator-to-output
// conversion used by the output dense layer (dnn_layer2) and its MAC lanes.
//
// Build option:
//   DNN2_SAT_EN  defined   -> results saturate to the signed OUT_SIZE range
//                undefined -> results are the low OUT_SIZE bits (two's-complement wrap)
package gnn_pkg;

  localparam int IN_SIZE   = 21;
  localparam int W_SIZE    = 5;
  localparam int ACC_SIZE  = 28;
  localparam int OUT_SIZE  = 21;
  localparam int PROD_SIZE = IN_SIZE + W_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [OUT_SIZE-1:0] acc_to_out(input logic signed [ACC_SIZE-1:0] acc);
`ifdef DNN2_SAT_EN
    // The value fits in OUT_SIZE signed bits exactly when every bit from the
    // OUT_SIZE-1 position up to the sign bit is a copy of the sign.
    if (!acc[ACC_SIZE-1] && (acc[ACC_SIZE-2:OUT_SIZE-1] != '0))
      return {1'b0, {(OUT_SIZE-1){1'b1}}};
    else if (acc[ACC_SIZE-1] && (acc[ACC_SIZE-2:OUT_SIZE-1] != '1))
      return {1'b1, {(OUT_SIZE-1){1'b0}}};
    else
      return acc[OUT_SIZE-1:0];
`else
    return acc[OUT_SIZE-1:0];
`endif
  endfunction

endpackage

// File: rtl/dnn2_mac_lane.sv
// dnn2_mac_lane: one output lane of dnn_layer2. Multiplies the presented
// feature by the presented weight, accumulates, and on load_out registers the
// converted accumulator onto result.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      zero the accumulator (start of a new computation)
//   mac_en     add feature*weight to the accumulator this cycle
//   load_out   register the converted accumulator onto result
//   feature    signed IN_SIZE operand
//   weight     signed W_SIZE operand
//   result     OUT_SIZE result, held until the next load_out or reset
module dnn2_mac_lane
  import gnn_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       mac_en,
  input  logic                       load_out,
  input  logic signed [IN_SIZE-1:0]  feature,
  input  logic signed [W_SIZE-1:0]   weight,
  output logic [OUT_SIZE-1:0]        result
);

  logic signed [PROD_SIZE-1:0] product;
  logic signed [ACC_SIZE-1:0]  acc;

  assign product = feature * weight;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clear)
        acc <= '0;
      else if (mac_en)
        acc <= acc + {{(ACC_SIZE-PROD_SIZE){product[PROD_SIZE-1]}}, product};
      if (load_out)
        result <= acc_to_out(acc);
    end
  end

endmodule

// File: rtl/dnn_layer2.sv
// dnn_layer2: output dense layer. For each of 4 nodes computes
//   out0 = sum_k in_k * w(k+4)8   and   out1 = sum_k in_k * w(k+4)9,  k = 0..3
// as a time-multiplexed MAC (one term per cycle, 8 lanes in parallel).
// Results appear 5 edges after the in_ready sample, with a one-cycle ready
// pulse on all 8 flags together.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_ready                       start strobe (ignored while busy)
//   in<k>_n<n>                     signed relu features, node n, term k
//   w48..w78 / w49..w79            signed weights for out0 / out1
//   out0_node<n>, out1_node<n>     results
//   out10_ready_node<n>,
//   out11_ready_node<n>            result-valid pulses
//
// Build option: DNN2_SAT_EN selects saturating result conversion (see gnn_pkg).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_ready; inputs/weights latched on the start edge
// MAC   | one term per edge, idx 0..3
// DONE  | accumulators converted onto outputs, ready pulse raised
module dnn_layer2
  import gnn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_ready,
  input  logic signed [IN_SIZE-1:0] in0_n0, in1_n0, in2_n0, in3_n0,
  input  logic signed [IN_SIZE-1:0] in0_n1, in1_n1, in2_n1, in3_n1,
  input  logic signed [IN_SIZE-1:0] in0_n2, in1_n2, in2_n2, in3_n2,
  input  logic signed [IN_SIZE-1:0] in0_n3, in1_n3, in2_n3, in3_n3,
  input  logic signed [W_SIZE-1:0]  w48, w58, w68, w78,
  input  logic signed [W_SIZE-1:0]  w49, w59, w69, w79,
  output logic [OUT_SIZE-1:0]       out0_node0, out0_node1, out0_node2, out0_node3,
  output logic [OUT_SIZE-1:0]       out1_node0, out1_node1, out1_node2, out1_node3,
  output logic                      out10_ready_node0, out10_ready_node1,
  output logic                      out10_ready_node2, out10_ready_node3,
  output logic                      out11_ready_node0, out11_ready_node1,
  output logic                      out11_ready_node2, out11_ready_node3
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_MAC  = MAC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0] state;
  logic [1:0] idx;
  logic       ready;
  logic       start;

  logic signed [IN_SIZE-1:0] in_bus [4][4];
  logic signed [W_SIZE-1:0]  w0_bus [4];
  logic signed [W_SIZE-1:0]  w1_bus [4];

  logic signed [IN_SIZE-1:0] in_lat [4][4];
  logic signed [W_SIZE-1:0]  w0_lat [4];
  logic signed [W_SIZE-1:0]  w1_lat [4];

  logic signed [IN_SIZE-1:0] feat_sel [4];
  logic signed [W_SIZE-1:0]  w0_sel;
  logic signed [W_SIZE-1:0]  w1_sel;

  logic [OUT_SIZE-1:0] res0 [4];
  logic [OUT_SIZE-1:0] res1 [4];

  // in_bus[node][term]
  assign in_bus[0][0] = in0_n0;  assign in_bus[0][1] = in1_n0;
  assign in_bus[0][2] = in2_n0;  assign in_bus[0][3] = in3_n0;
  assign in_bus[1][0] = in0_n1;  assign in_bus[1][1] = in1_n1;
  assign in_bus[1][2] = in2_n1;  assign in_bus[1][3] = in3_n1;
  assign in_bus[2][0] = in0_n2;  assign in_bus[2][1] = in1_n2;
  assign in_bus[2][2] = in2_n2;  assign in_bus[2][3] = in3_n2;
  assign in_bus[3][0] = in0_n3;  assign in_bus[3][1] = in1_n3;
  assign in_bus[3][2] = in2_n3;  assign in_bus[3][3] = in3_n3;

  assign w0_bus[0] = w48;  assign w0_bus[1] = w58;
  assign w0_bus[2] = w68;  assign w0_bus[3] = w78;
  assign w1_bus[0] = w49;  assign w1_bus[1] = w59;
  assign w1_bus[2] = w69;  assign w1_bus[3] = w79;

  assign start = (state == ST_IDLE) && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= 2'd0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_ready) begin
            idx   <= 2'd0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3)
            state <= ST_DONE;
        end
        ST_DONE: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand latches need no reset: they are only read in MAC, which is
  // always entered through a load.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int n = 0; n < 4; n++)
        for (int k = 0; k < 4; k++)
          in_lat[n][k] <= in_bus[n][k];
      for (int k = 0; k < 4; k++) begin
        w0_lat[k] <= w0_bus[k];
        w1_lat[k] <= w1_bus[k];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++)
      feat_sel[n] = in_lat[n][idx];
    w0_sel = w0_lat[idx];
    w1_sel = w1_lat[idx];
  end

  for (genvar n = 0; n < 4; n++) begin : g_node
    dnn2_mac_lane u_lane0 (
      .clk      (clk),
      .rst      (rst),
      .clear    (start),
      .mac_en   (state == ST_MAC),
      .load_out (state == ST_DONE),
      .feature  (feat_sel[n]),
      .weight   (w0_sel),
      .result   (res0[n])
    );
    dnn2_mac_lane u_lane1 (
      .clk      (clk),
      .rst      (rst),
      .clear    (start),
      .mac_en   (state == ST_MAC),
      .load_out (state == ST_DONE),
      .feature  (feat_sel[n]),
      .weight   (w1_sel),
      .result   (res1[n])
    );
  end

  assign out0_node0 = res0[0];  assign out0_node1 = res0[1];
  assign out0_node2 = res0[2];  assign out0_node3 = res0[3];
  assign out1_node0 = res1[0];  assign out1_node1 = res1[1];
  assign out1_node2 = res1[2];  assign out1_node3 = res1[3];

  assign out10_ready_node0 = ready;  assign out10_ready_node1 = ready;
  assign out10_ready_node2 = ready;  assign out10_ready_node3 = ready;
  assign out11_ready_node0 = ready;  assign out11_ready_node1 = ready;
  assign out11_ready_node2 = ready;  assign out11_ready_node3 = ready;

endmodule

// File: tb/tb_dnn_layer2.sv
// tb_dnn_layer2: directed + random bench for dnn_layer2 against a plain
// arithmetic reference (weighted sums, then wrap or saturate to 21 bits).
module tb_dnn_layer2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_ready = 1'b0;

  logic signed [20:0] tin [4][4];
  logic signed [4:0]  tw0 [4];
  logic signed [4:0]  tw1 [4];

  logic [20:0] o0 [4];
  logic [20:0] o1 [4];
  logic        r10 [4];
  logic        r11 [4];

  logic [20:0] exp0 [4];
  logic [20:0] exp1 [4];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dnn_layer2 dut (
    .clk(clk), .rst(rst), .in_ready(in_ready),
    .in0_n0(tin[0][0]), .in1_n0(tin[0][1]), .in2_n0(tin[0][2]), .in3_n0(tin[0][3]),
    .in0_n1(tin[1][0]), .in1_n1(tin[1][1]), .in2_n1(tin[1][2]), .in3_n1(tin[1][3]),
    .in0_n2(tin[2][0]), .in1_n2(tin[2][1]), .in2_n2(tin[2][2]), .in3_n2(tin[2][3]),
    .in0_n3(tin[3][0]), .in1_n3(tin[3][1]), .in2_n3(tin[3][2]), .in3_n3(tin[3][3]),
    .w48(tw0[0]), .w58(tw0[1]), .w68(tw0[2]), .w78(tw0[3]),
    .w49(tw1[0]), .w59(tw1[1]), .w69(tw1[2]), .w79(tw1[3]),
    .out0_node0(o0[0]), .out0_node1(o0[1]), .out0_node2(o0[2]), .out0_node3(o0[3]),
    .out1_node0(o1[0]), .out1_node1(o1[1]), .out1_node2(o1[2]), .out1_node3(o1[3]),
    .out10_ready_node0(r10[0]), .out10_ready_node1(r10[1]),
    .out10_ready_node2(r10[2]), .out10_ready_node3(r10[3]),
    .out11_ready_node0(r11[0]), .out11_ready_node1(r11[1]),
    .out11_ready_node2(r11[2]), .out11_ready_node3(r11[3])
  );

  function automatic logic [20:0] to_out(input longint s);
    longint t;
    t = s;
`ifdef DNN2_SAT_EN
    if (t > 64'sd1048575)  t = 64'sd1048575;
    if (t < -64'sd1048576) t = -64'sd1048576;
`endif
    return t[20:0];
  endfunction

  function automatic logic [7:0] rdy_all();
    return {r11[3], r11[2], r11[1], r11[0], r10[3], r10[2], r10[1], r10[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [20:0] got, input logic [20:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_rdy(input string tag, input logic [7:0] want);
    logic [7:0] got;
    got = rdy_all();
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: ready got %b expected %b", tag, got, want);
    end
  endtask

  task automatic compute_expected();
    for (int n = 0; n < 4; n++) begin
      longint s0, s1;
      s0 = 0;
      s1 = 0;
      for (int k = 0; k < 4; k++) begin
        s0 += longint'(tin[n][k]) * longint'(tw0[k]);
        s1 += longint'(tin[n][k]) * longint'(tw1[k]);
      end
      exp0[n] = to_out(s0);
      exp1[n] = to_out(s1);
    end
  endtask

  task automatic randomize_operands();
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++)
        tin[n][k] = 21'($urandom);
    for (int k = 0; k < 4; k++) begin
      tw0[k] = 5'($urandom);
      tw1[k] = 5'($urandom);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int n = 0; n < 4; n++) begin
      check_val($sformatf("%s out0_node%0d", tag, n), o0[n], exp0[n]);
      check_val($sformatf("%s out1_node%0d", tag, n), o1[n], exp1[n]);
    end
  endtask

  // Samples edge T with the current operands, then follows edges T+1..T+5.
  // With busy set, operands are scrambled after T and a second in_ready is
  // presented at T+2; neither may influence the result or add a pulse.
  task automatic run_op(input string tag, input bit busy);
    compute_expected();
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    check_rdy({tag, " rdy@T"}, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      if (busy && (c == 1)) randomize_operands();
      if (busy && (c == 2)) begin
        randomize_operands();
        in_ready = 1'b1;
      end
      step();
      in_ready = 1'b0;
      if (c < 5) check_rdy($sformatf("%s rdy@T+%0d", tag, c), 8'h00);
      else       check_rdy({tag, " rdy@T+5"}, 8'hFF);
    end
    check_outputs(tag);
  endtask

  initial begin
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++)
        tin[n][k] = '0;
    for (int k = 0; k < 4; k++) begin
      tw0[k] = '0;
      tw1[k] = '0;
    end

    // Reset
    rst = 1'b1;
    step();
    step();
    for (int n = 0; n < 4; n++) begin
      exp0[n] = '0;
      exp1[n] = '0;
    end
    check_outputs("reset");
    check_rdy("reset rdy", 8'h00);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check_outputs("idle");
    check_rdy("idle rdy", 8'h00);

    // Basic directed case
    randomize_operands();
    tin[0][0] = 21'sd1; tin[0][1] = 21'sd2; tin[0][2] = 21'sd3; tin[0][3] = 21'sd4;
    for (int k = 0; k < 4; k++) tw0[k] = 5'sd1;
    tw1[0] = -5'sd1; tw1[1] = 5'sd0; tw1[2] = 5'sd0; tw1[3] = 5'sd2;
    run_op("basic", 1'b0);
    check_val("basic const out0_node0", o0[0], 21'd10);
    check_val("basic const out1_node0", o1[0], 21'd7);
    step();
    check_rdy("basic rdy@T+6", 8'h00);

    // Large positive and large negative sums
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++)
        tin[n][k] = 21'sd1048575;
    for (int k = 0; k < 4; k++) begin
      tw0[k] = 5'sd15;
      tw1[k] = -5'sd16;
    end
    run_op("sat", 1'b0);
`ifdef DNN2_SAT_EN
    check_val("sat const pos", o0[0], 21'h0FFFFF);
    check_val("sat const neg", o1[0], 21'h100000);
`else
    check_val("wrap const pos", o0[0], 21'h1FFFC4);
    check_val("wrap const neg", o1[0], 21'h000040);
`endif

    // Busy: second strobe and operand changes ignored
    randomize_operands();
    run_op("busy", 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      check_rdy($sformatf("busy no 2nd pulse %0d", c), 8'h00);
    end
    check_outputs("busy hold");

    // Reset in the middle of a computation
    randomize_operands();
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      exp0[n] = '0;
      exp1[n] = '0;
    end
    for (int c = 0; c < 6; c++) begin
      step();
      check_rdy($sformatf("midrst rdy %0d", c), 8'h00);
    end
    check_outputs("midrst");
    randomize_operands();
    run_op("after midrst", 1'b0);

    // Back-to-back: next start sampled on the edge right after the pulse
    randomize_operands();
    run_op("b2b first", 1'b0);
    randomize_operands();
    run_op("b2b second", 1'b0);

    // Random operations with idle gaps
    for (int i = 0; i < 20; i++) begin
      randomize_operands();
      run_op($sformatf("rand%0d", i), 1'b0);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
      check_outputs($sformatf("rand%0d hold", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dnn_layer2.md
Name: dnn_layer2

Overview:
Second (output) dense layer of the GNN. It sits directly downstream of relu_4n and consumes that block's 16 rectified features: four nodes, in0..in3 each.
For every node it computes two weighted sums, out0 = Σ in_k·w(k+4)8 and out1 = Σ in_k·w(k+4)9 for k = 0..3, using weights w48..w78 and w49..w79. It drives the top-level out0_node*/out1_node* results and the out10_ready_node*/out11_ready_node* flags.
Computation is a time-multiplexed MAC: one term per cycle, all 8 lanes in parallel.

Parameters:
IN_SIZE, 21, signed width of each relu input
W_SIZE, 5, signed width of each weight
ACC_SIZE, 28, signed accumulator width (IN_SIZE+W_SIZE+2, no overflow possible)
OUT_SIZE, 21, signed width of each result

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_ready  input  1  start strobe from relu_4n (its relu_ready)
in0_n0..in3_n0, in0_n1..in3_n1, in0_n2..in3_n2, in0_n3..in3_n3  input  IN_SIZE each  relu features per node
w48, w58, w68, w78  input  W_SIZE each  weights for out0
w49, w59, w69, w79  input  W_SIZE each  weights for out1
out0_node0..out0_node3, out1_node0..out1_node3  output  OUT_SIZE each  results
out10_ready_node0..3, out11_ready_node0..3  output  1 each  result-valid pulses

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, all accumulators 0, all outputs 0, all ready flags 0. A reset asserted mid-operation discards the in-flight computation; no ready flag is produced for it.
- FSM states: IDLE, MAC, DONE.
- IDLE: at the edge where in_ready=1 (call it T):
  - latch all 16 inputs and 8 weights into internal registers;
  - clear the accumulators, set idx=0, go to MAC.
- MAC: on each edge T+1..T+4, every lane adds latched in_idx × latched weight_idx to its accumulator, then idx++.
  - Multiply is signed, IN_SIZE×W_SIZE → 26 bits, sign-extended to ACC_SIZE.
  - After the idx=3 term (edge T+4), go to DONE.
- DONE: at edge T+5:
  - each accumulator is converted to OUT_SIZE and registered onto its out port;
  - all 8 ready flags go high for exactly one cycle (cleared at T+6);
  - state returns to IDLE.
- Latency: 5 clock edges from in_ready sample to ready high. The earliest next start is sampled at T+6.
- Outputs hold their value until the next DONE or reset. The ready flags of all 8 lanes always assert together.
- in_ready while in MAC or DONE is ignored. There is no queueing.
- Input or weight changes after edge T do not affect the current result.
- Width conversion: see Optional Feature.

Optional Feature:
Macro DNN2_SAT_EN.
- Defined: saturating conversion. Accumulator > 2^(OUT_SIZE-1)-1 → 0x0FFFFF; accumulator < -2^(OUT_SIZE-1) → 0x100000; otherwise the low OUT_SIZE bits.
- Undefined: plain truncation to the low OUT_SIZE bits (two's-complement wrap).

Decomposition:
- gnn_pkg holds:
  - the IN_SIZE/W_SIZE/ACC_SIZE/OUT_SIZE constants;
  - the state enum (IDLE/MAC/DONE);
  - the saturate/truncate conversion function.
- Sub-module dnn2_mac_lane: one accumulator plus multiplier and the output conversion. It is instantiated 8 times (2 outputs × 4 nodes).
- dnn_layer2 owns the FSM, the idx counter, the input/weight latches, the per-lane term muxing and the ready generation.

Test Plan:
- Reset: rst=1 for 2 cycles → all out*=0, all ready=0, FSM idle. rst=0 with no in_ready → outputs stay 0.
- Basic MAC: node0 in=1,2,3,4; w48..w78=1,1,1,1; w49..w79=-1,0,0,2; in_ready 1 cycle at T → out0_node0=10, out1_node0=7. All 8 ready flags high only in the cycle after T+5.
- Saturation: all inputs 1048575; weights all 15 → with DNN2_SAT_EN, outputs = 0x0FFFFF; without it, outputs = 0x1FFFC4 (-60). Weights all -16 → with DNN2_SAT_EN, outputs = 0x100000.
- Busy ignore: second in_ready at T+2 with different inputs, and inputs changed after T → only one ready pulse, at T+5, with the result computed from the T values.
- Reset mid-operation: rst=1 at T+2 → no ready pulse, outputs 0. Next in_ready after reset computes correctly.
- Back-to-back: in_ready at T and at T+6 with new values → two ready pulses at T+5 and T+11, each with the correct results.
